// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Scan controller for a multi-digit 7-segment display. Each digit has its own
// segment register, which the processor writes over a single-cycle strobe
// interface. The registers are time-multiplexed onto one shared active-low
// segment bus. Every digit slot starts with a blanking gap, during which the
// bus is dark and no digit is enabled, so that the previous pattern does not
// ghost onto the next digit.
//
// Each slot lasts exactly SCAN_DIV clocks: BLANK clocks dark, then the rest
// active. The segment pattern is latched when the slot goes active, so a write
// to the digit on display shows up on that digit's next visit.
//
// Optional feature: define SEG7_BLINK_EN to add the blink_i port. With it, a
// blink phase toggles every BLINK_FR full frames. While the phase is 1, any
// digit whose blink_i bit is set shows dark during its active time, but its
// digit enable still asserts.
//
// Ports
//   clock_i   in   1      rising-edge clock
//   resetn_i  in   1      asynchronous active-low reset
//   run_i     in   1      1 = scan enabled, 0 = display dark and scan parked
//   w_i       in   1      write strobe, qualified for one cycle
//   addr_i    in   AW     digit index for the write; indices >= NDIG are ignored
//   din_i     in   SEG_W  segment pattern written to digit addr_i
//   blink_i   in   NDIG   per-digit blink mask (only with SEG7_BLINK_EN)
//   seg_o     out  SEG_W  registered segment bus, active-low
//   dig_en_o  out  NDIG   registered one-hot digit enable, active-high
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NDIG     = 6,
  parameter int SEG_W    = 7,
  parameter int AW       = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 16,
  parameter int BLINK_FR = 32
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              run_i,
  input  logic              w_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [SEG_W-1:0]  din_i,
`ifdef SEG7_BLINK_EN
  input  logic [NDIG-1:0]   blink_i,
`endif
  output logic [SEG_W-1:0]  seg_o,
  output logic [NDIG-1:0]   dig_en_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0]    BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]    SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST   = IW'(NDIG - 1);
  localparam logic [SEG_W-1:0] DARK       = '1;

  // Reject parameter sets the scan timing cannot honour.
  if (SCAN_DIV <= BLANK) begin : g_bad_div
    $error("SCAN_DIV must exceed BLANK");
  end
  if (BLANK < 1) begin : g_bad_blank
    $error("BLANK must be at least 1");
  end
  if ((1 << AW) < NDIG) begin : g_bad_aw
    $error("AW too narrow to address NDIG digits");
  end
  if (BLINK_FR < 1) begin : g_bad_fr
    $error("BLINK_FR must be at least 1");
  end

  typedef enum logic {BLNK, ACT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [NDIG-1:0]  dig_en_q, dig_en_d;
  logic [SEG_W-1:0] digit_q [NDIG];
  logic [NDIG-1:0]  wr_sel;
  logic             blank_sel;

  // Address decode: an index with no matching digit selects nothing, which
  // is what makes out-of-range writes harmless.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_wr_sel
    assign wr_sel[gi] = w_i && (addr_i == AW'(gi));
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NDIG; i++) begin
        digit_q[i] <= DARK;
      end
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (wr_sel[i]) begin
          digit_q[i] <= din_i;
        end
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FR - 1);

  logic [FW-1:0] fr_q, fr_d;
  logic          phase_q, phase_d;
  logic          frame_done;

  // A frame completes on the edge where the last digit's slot wraps back to
  // digit 0. A parked scan (run_i low) completes nothing.
  assign frame_done = run_i && (state_q == ACT) && (cnt_q == SLOT_LAST) &&
                      (idx_q == IDX_LAST);

  always_comb begin
    fr_d    = fr_q;
    phase_d = phase_q;
    if (frame_done) begin
      if (fr_q == FR_LAST) begin
        fr_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fr_d = fr_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      fr_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      fr_q    <= fr_d;
      phase_q <= phase_d;
    end
  end

  assign blank_sel = phase_q && blink_i[idx_q];
`else
  assign blank_sel = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    seg_d    = seg_q;
    dig_en_d = dig_en_q;
    if (!run_i) begin
      // Park the scan so that raising run_i restarts at digit 0 with a full gap.
      state_d  = BLNK;
      cnt_d    = '0;
      idx_d    = '0;
      seg_d    = DARK;
      dig_en_d = '0;
    end else begin
      case (state_q)
        BLNK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) begin
            // The pattern is captured here and held for the whole active
            // period, so mid-slot writes never tear the displayed digit.
            state_d  = ACT;
            seg_d    = blank_sel ? DARK : digit_q[idx_q];
            dig_en_d = NDIG'(1) << idx_q;
          end
        end
        ACT: begin
          if (cnt_q == SLOT_LAST) begin
            state_d  = BLNK;
            cnt_d    = '0;
            idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            seg_d    = DARK;
            dig_en_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = BLNK;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= BLNK;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= DARK;
      dig_en_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg_o    = seg_q;
  assign dig_en_o = dig_en_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Exercises seg7_scan_ctrl with 4 digits, 8-clock slots and 2 blank clocks.
// Each table entry describes one frame. It holds an optional write, given as
// the frame offset at which the write is driven, plus the segment value
// expected in each of the four slots of that frame. The expected slots are
// queued when the frame is started.
//
// A negedge monitor pops one entry per slot activation. It also checks:
//   - blank and active lengths,
//   - hold stability during the active period,
//   - the one-hot invariant on the digit enable,
//   - that the bus is dark whenever no digit is enabled.
//
// Hand-written sequences cover Run dropping mid-slot and an async reset
// mid-slot. With SEG7_BLINK_EN defined, they also cover blinking.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int SEG_W    = 7;
  localparam int AW       = 3;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int BLINK_FR = 2;
  localparam int FRAME    = NDIG * SCAN_DIV;
  localparam int ACT_LEN  = SCAN_DIV - BLANK;

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic             run    = 1'b1;
  logic             w      = 1'b0;
  logic [AW-1:0]    addr   = '0;
  logic [SEG_W-1:0] din    = '0;
  logic [SEG_W-1:0] seg;
  logic [NDIG-1:0]  dig_en;
`ifdef SEG7_BLINK_EN
  logic [NDIG-1:0]  blink  = '0;
`endif

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NDIG(NDIG), .SEG_W(SEG_W), .AW(AW),
    .SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .BLINK_FR(BLINK_FR)
  ) dut (
    .clock_i  (clk),
    .resetn_i (resetn),
    .run_i    (run),
    .w_i      (w),
    .addr_i   (addr),
    .din_i    (din),
`ifdef SEG7_BLINK_EN
    .blink_i  (blink),
`endif
    .seg_o    (seg),
    .dig_en_o (dig_en)
  );

  typedef struct {
    logic                      w;
    logic [AW-1:0]             addr;
    logic [SEG_W-1:0]          din;
    int                        at;
    logic [NDIG-1:0][SEG_W-1:0] exp_seg;
  } vec_t;

  typedef struct {
    logic [NDIG-1:0]  en;
    logic [SEG_W-1:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic vec_t mk(input logic wv, input logic [AW-1:0] a,
                              input logic [SEG_W-1:0] d, input int at,
                              input logic [SEG_W-1:0] s0, input logic [SEG_W-1:0] s1,
                              input logic [SEG_W-1:0] s2, input logic [SEG_W-1:0] s3);
    vec_t v;
    v.w          = wv;
    v.addr       = a;
    v.din        = d;
    v.at         = at;
    v.exp_seg[0] = s0;
    v.exp_seg[1] = s1;
    v.exp_seg[2] = s2;
    v.exp_seg[3] = s3;
    return v;
  endfunction

  task automatic push_slot(input int i, input logic [SEG_W-1:0] v);
    exp_t e;
    e.en  = NDIG'(1 << i);
    e.seg = v;
    exp_q.push_back(e);
  endtask

  task automatic push4(input logic [SEG_W-1:0] s0, input logic [SEG_W-1:0] s1,
                       input logic [SEG_W-1:0] s2, input logic [SEG_W-1:0] s3);
    push_slot(0, s0);
    push_slot(1, s1);
    push_slot(2, s2);
    push_slot(3, s3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a frame-start edge, and returns just after the next one.
  task automatic run_vec(input int n, input vec_t v);
    push4(v.exp_seg[0], v.exp_seg[1], v.exp_seg[2], v.exp_seg[3]);
    $display("frame %0d: w=%0b addr=%0d din=%h at=%0d", n, v.w, v.addr, v.din, v.at);
    for (int e = 0; e < FRAME; e++) begin
      if (v.w && e == v.at) begin
        w    = 1'b1;
        addr = v.addr;
        din  = v.din;
      end
      step();
      w = 1'b0;
    end
  endtask

  // Slot monitor
  initial begin
    logic [NDIG-1:0]  prev_en   = '0;
    logic [SEG_W-1:0] held_seg  = '1;
    int               blank_len = 0;
    int               act_len   = 0;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("onehot0", 32'($onehot0(dig_en)), 32'd1);
        if (dig_en == '0) check("dark_when_idle", 32'(seg), 32'h7F);
        if (!resetn || !run) begin
          blank_len = 0;
          act_len   = 0;
        end else if (dig_en == '0) begin
          if (prev_en != '0) check("active_len", 32'(act_len), 32'(ACT_LEN));
          blank_len++;
          act_len = 0;
        end else if (prev_en == '0) begin
          check("blank_len", 32'(blank_len), 32'(BLANK));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_slot: got en=%b seg=%h, expected no activation", dig_en, seg);
          end else begin
            e = exp_q.pop_front();
            check("slot_en", 32'(dig_en), 32'(e.en));
            check("slot_seg", 32'(seg), 32'(e.seg));
            $display("slot: en=%b seg=%h (expected en=%b seg=%h)", dig_en, seg, e.en, e.seg);
          end
          held_seg  = seg;
          act_len   = 1;
          blank_len = 0;
        end else begin
          check("hold_en", 32'(dig_en), 32'(prev_en));
          check("hold_seg", 32'(seg), 32'(held_seg));
          act_len++;
        end
        prev_en = dig_en;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[13];
`ifdef SEG7_BLINK_EN
  vec_t btbl[6];
`endif

  initial begin
    tbl[0]  = mk(1'b0, 3'd0, 7'h00,  0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tbl[1]  = mk(1'b0, 3'd0, 7'h00,  0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tbl[2]  = mk(1'b1, 3'd0, 7'h40,  0, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    tbl[3]  = mk(1'b1, 3'd3, 7'h79,  0, 7'h40, 7'h7F, 7'h7F, 7'h79);
    tbl[4]  = mk(1'b1, 3'd5, 7'h00,  3, 7'h40, 7'h7F, 7'h7F, 7'h79);
    tbl[5]  = mk(1'b1, 3'd4, 7'h00, 10, 7'h40, 7'h7F, 7'h7F, 7'h79);
    tbl[6]  = mk(1'b1, 3'd1, 7'h24, 12, 7'h40, 7'h7F, 7'h7F, 7'h79);
    tbl[7]  = mk(1'b0, 3'd0, 7'h00,  0, 7'h40, 7'h24, 7'h7F, 7'h79);
    tbl[8]  = mk(1'b1, 3'd2, 7'h12, 17, 7'h40, 7'h24, 7'h7F, 7'h79);
    tbl[9]  = mk(1'b0, 3'd0, 7'h00,  0, 7'h40, 7'h24, 7'h12, 7'h79);
    tbl[10] = mk(1'b1, 3'd2, 7'h3F, 16, 7'h40, 7'h24, 7'h3F, 7'h79);
    tbl[11] = mk(1'b1, 3'd0, 7'h00, 31, 7'h40, 7'h24, 7'h3F, 7'h79);
    tbl[12] = mk(1'b0, 3'd0, 7'h00,  0, 7'h00, 7'h24, 7'h3F, 7'h79);
`ifdef SEG7_BLINK_EN
    btbl[0] = mk(1'b1, 3'd2, 7'h12, 0, 7'h7F, 7'h7F, 7'h12, 7'h7F);
    btbl[1] = mk(1'b1, 3'd0, 7'h08, 0, 7'h08, 7'h7F, 7'h12, 7'h7F);
    btbl[2] = mk(1'b0, 3'd0, 7'h00, 0, 7'h08, 7'h7F, 7'h7F, 7'h7F);
    btbl[3] = mk(1'b0, 3'd0, 7'h00, 0, 7'h08, 7'h7F, 7'h7F, 7'h7F);
    btbl[4] = mk(1'b0, 3'd0, 7'h00, 0, 7'h08, 7'h7F, 7'h12, 7'h7F);
    btbl[5] = mk(1'b0, 3'd0, 7'h00, 0, 7'h08, 7'h7F, 7'h12, 7'h7F);
`endif

    // Reset state
    resetn = 1'b0;
    run    = 1'b1;
    repeat (3) step();
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_en", 32'(dig_en), 32'h0);
    mon_on = 1'b1;
    resetn = 1'b1;

    // Frame-by-frame table: dark scan, writes, ignored addresses, latch timing
    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // Run dropped while slot 2 is active, then restarted
    push_slot(0, 7'h00);
    push_slot(1, 7'h24);
    push_slot(2, 7'h3F);
    repeat (20) step();
    run = 1'b0;
    step();
    check("run0_en", 32'(dig_en), 32'h0);
    check("run0_seg", 32'(seg), 32'h7F);
    repeat (3) step();
    check("run0_hold_en", 32'(dig_en), 32'h0);
    run = 1'b1;
    push4(7'h00, 7'h24, 7'h3F, 7'h79);
    step();
    check("restart_gap", 32'(dig_en), 32'h0);
    step();
    check("restart_first_en", 32'(dig_en), 32'h1);
    check("restart_first_seg", 32'(seg), 32'h00);
    repeat (FRAME - 2) step();

    // Asynchronous reset while slot 0 is active
    push_slot(0, 7'h00);
    repeat (4) step();
    check("pre_reset_en", 32'(dig_en), 32'h1);
    resetn = 1'b0;
    #1;
    check("async_reset_en", 32'(dig_en), 32'h0);
    check("async_reset_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    step();
    resetn = 1'b1;
    $display("after reset: all digits expected dark");
    push4(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    repeat (FRAME) step();

`ifdef SEG7_BLINK_EN
    // Blink: fresh reset so the frame counter and phase start from zero
    resetn = 1'b0;
    blink  = 4'b0100;
    repeat (2) step();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(100 + i, btbl[i]);
`endif

    repeat (2) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
